// File: rtl/mc_main_ctrl_if.sv
// Control bus between the multi-cycle main controller and the MIPS datapath.
// The master (controller) drives every strobe and select; the slave supplies the opcode and the memory handshake.
interface mc_main_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       Op;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic [1:0]       PCSource;
    logic [1:0]       ALUOp;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic             RegWrite;
    logic             RegDst;
    logic [3:0]       state;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  Op, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
               state, illegal_op, instr_count
    );

    modport slave (
        output Op, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
               state, illegal_op, instr_count
    );
endinterface

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory-ready stalls, sticky illegal-opcode flag and a retired-instruction counter.
module mc_main_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    mc_main_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_e;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       fetch;
        logic       memtoreg;
        logic [1:0] pcsource;
        logic [1:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       regwrite;
        logic       regdst;
    } ctl_t;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    function automatic ctl_t decode(state_e s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.memread = 1'b1; c.fetch = 1'b1; c.alusrcb = 2'b01; end
            S_DECODE: c.alusrcb = 2'b11;
            S_MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:  begin c.memread = 1'b1; c.iord = 1'b1; end
            S_MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
            S_MEMWR:  begin c.memwrite = 1'b1; c.iord = 1'b1; end
            S_EXEC:   begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            S_ALUWB:  begin c.regwrite = 1'b1; c.regdst = 1'b1; end
            S_BRANCH: begin
                c.alusrca = 1'b1; c.aluop = 2'b01; c.pcwritecond = 1'b1; c.pcsource = 2'b01;
            end
            S_JUMP:   begin c.pcwrite = 1'b1; c.pcsource = 2'b10; end
            S_ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_ADDIWB: c.regwrite = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_e           state_q, state_d;
    ctl_t             ctl_q;
    logic             sw_q, sw_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    always_comb begin
        state_d = state_q;
        sw_d    = sw_q;
        ill_d   = ill_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                // Only lw/sw need the opcode past DECODE, so one bit is kept.
                sw_d = (bus.Op == OP_SW);
                case (bus.Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        state_d = S_FETCH;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_IDLE;
        endcase
        cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
    end

    // Outputs are registered from the next state so they are glitch-free Moore decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ctl_q   <= '0;
            sw_q    <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= decode(state_d);
            sw_q    <= sw_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    // IR/PC load in FETCH is qualified by the memory handshake in the same cycle.
    assign bus.IRWrite     = ctl_q.fetch & bus.mem_ready;
    assign bus.PCWrite     = ctl_q.pcwrite | (ctl_q.fetch & bus.mem_ready);
    assign bus.PCWriteCond = ctl_q.pcwritecond;
    assign bus.IorD        = ctl_q.iord;
    assign bus.MemRead     = ctl_q.memread;
    assign bus.MemWrite    = ctl_q.memwrite;
    assign bus.MemtoReg    = ctl_q.memtoreg;
    assign bus.PCSource    = ctl_q.pcsource;
    assign bus.ALUOp       = ctl_q.aluop;
    assign bus.ALUSrcA     = ctl_q.alusrca;
    assign bus.ALUSrcB     = ctl_q.alusrcb;
    assign bus.RegWrite    = ctl_q.regwrite;
    assign bus.RegDst      = ctl_q.regdst;
    assign bus.state       = state_q;
    assign bus.illegal_op  = ill_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: per-instruction state paths from the ISA rules feed an
// expectation queue that a negedge monitor drains against the DUT.
module tb_mc_main_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_main_ctrl_if #(.CNT_W(CW)) bus ();
  mc_main_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [3:0]    st;
    logic [15:0]   ctl;
    logic          ill;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t expq[$];
  int checks = 0;
  int failures = 0;
  int cnt_m = 0;
  bit ill_m = 1'b0;

  // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg PCSource ALUOp ALUSrcA ALUSrcB RegWrite RegDst
  function automatic logic [15:0] ctl_of(int s, bit mr);
    logic pw = 0, pwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, asa = 0, rw = 0, rd = 0;
    logic [1:0] pcs = 0, aop = 0, asb = 0;
    case (s)
      1:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      2:  asb = 2'b11;
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rw = 1; rd = 1; end
      9:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
      10: begin pw = 1; pcs = 2'b10; end
      11: begin asa = 1; asb = 2'b10; end
      12: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iord, mrd, mwr, irw, m2r, pcs, aop, asa, asb, rw, rd};
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st  = bus.state;
    o.ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
             bus.MemtoReg, bus.PCSource, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.RegDst};
    o.ill = bus.illegal_op;
    o.cnt = bus.instr_count;
    return o;
  endfunction

  task automatic check(string name, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got st=%0d ctl=%h ill=%b cnt=%0d want st=%0d ctl=%h ill=%b cnt=%0d",
               name, $time, got.st, got.ctl, got.ill, got.cnt, exp.st, exp.ctl, exp.ill, exp.cnt);
    end
  endtask

  // One clock of stimulus: inputs for this cycle plus the state the rules say we are in.
  task automatic cyc(int s, bit mr, logic [5:0] op);
    obs_t e;
    @(posedge clk);
    #1;
    bus.mem_ready = mr;
    bus.Op = op;
    e.st  = 4'(s);
    e.ctl = ctl_of(s, mr);
    e.ill = ill_m;
    e.cnt = CW'(cnt_m % (1 << CW));
    expq.push_back(e);
  endtask

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // kind: 0 lw, 1 sw, 2 R-type, 3 beq, 4 j, 5 addi, 6 illegal
  task automatic run_instr(int kind, int fst, int mst);
    logic [5:0] op;
    case (kind)
      0: op = 6'd35;  1: op = 6'd43;  2: op = 6'd0;
      3: op = 6'd4;   4: op = 6'd2;   5: op = 6'd8;
      default: begin
        op = junk();
        while (op inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43}) op = junk();
      end
    endcase
    repeat (fst) cyc(1, 1'b0, junk());
    cyc(1, 1'b1, junk());
    cyc(2, rbit(), op);
    case (kind)
      0: begin
        cyc(3, rbit(), junk());
        repeat (mst) cyc(4, 1'b0, junk());
        cyc(4, 1'b1, junk());
        cyc(5, rbit(), junk());
        cnt_m++;
      end
      1: begin
        cyc(3, rbit(), junk());
        repeat (mst) cyc(6, 1'b0, junk());
        cyc(6, 1'b1, junk());
        cnt_m++;
      end
      2: begin cyc(7, rbit(), junk()); cyc(8, rbit(), junk()); cnt_m++; end
      3: begin cyc(9, rbit(), junk()); cnt_m++; end
      4: begin cyc(10, rbit(), junk()); cnt_m++; end
      5: begin cyc(11, rbit(), junk()); cyc(12, rbit(), junk()); cnt_m++; end
      default: ill_m = 1'b1;
    endcase
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("cycle", sample(), e);
    end
  end

  initial begin
    obs_t zero;
    zero = '0;
    bus.Op = 6'd0;
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    cyc(0, 1'b0, 6'd0);
    cyc(0, 1'b1, 6'd0);
    rst_n = 1'b1;

    run_instr(0, 0, 0);
    run_instr(2, 0, 0);
    run_instr(3, 0, 0);
    run_instr(1, 2, 3);
    run_instr(6, 0, 0);
    run_instr(4, 1, 0);
    run_instr(5, 0, 0);
    repeat (30) run_instr($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 2));

    // Reset pulse while MEMRD is stalled: everything must clear without waiting for a clock.
    cyc(1, 1'b1, junk());
    cyc(2, 1'b1, 6'd35);
    cyc(3, 1'b1, junk());
    cyc(4, 1'b0, junk());
    #6;
    rst_n = 1'b0;
    #1;
    check("async_reset", sample(), zero);
    cnt_m = 0;
    ill_m = 1'b0;
    cyc(0, 1'b1, junk());
    cyc(0, 1'b1, 6'd0);
    rst_n = 1'b1;

    repeat (20) run_instr($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 2));

    for (int i = 0; i < 20 && expq.size() > 0; i++) @(negedge clk);
    #1;
    if (expq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multi-cycle main control FSM for the MIPS datapath; sits directly upstream of the ALU control decoder and drives its 2-bit ALUOp input.
- Decodes the 6-bit opcode from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Asserts all datapath enables and mux selects, stalls on a memory-ready handshake, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Op  in  6  instruction[31:26] from the instruction register
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data select: 1 = MDR
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- ALUOp  out  2  00 = add, 01 = subtract, 10 = use funct field
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2
- RegWrite  out  1  register file write
- RegDst  out  1  1 = rd, 0 = rt
- state  out  4  current state, for debug
- illegal_op  out  1  sticky flag, set on an unsupported opcode
- instr_count  out  CNT_W  retired-instruction counter

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- On reset: state = IDLE (0), illegal_op = 0, instr_count = 0, and every control output = 0.
- Outputs are Moore decodes of the state register only. Op is sampled only in DECODE.
- State encoding: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, JUMP 10, ADDIEX 11, ADDIWB 12. Codes 13–15 recover to IDLE.
- Transitions:
  - IDLE -> FETCH, unconditionally, 1 cycle after reset release.
  - FETCH -> DECODE when mem_ready=1; otherwise hold in FETCH.
  - DECODE -> MEMADR (Op 35 lw or 43 sw), EXEC (0 R-type), BRANCH (4 beq), JUMP (2 j), ADDIEX (8 addi).
  - DECODE with any other Op -> FETCH, and illegal_op is set to 1.
  - MEMADR -> MEMRD (lw) or MEMWR (sw), using Op as sampled in DECODE (Op is held stable by the IR).
  - MEMRD -> MEMWB when mem_ready=1; otherwise hold.
  - MEMWR -> FETCH when mem_ready=1; otherwise hold.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
  - EXEC -> ALUWB; ADDIEX -> ADDIWB.
- Outputs per state (any output not listed is 0):
  - FETCH: MemRead=1, ALUSrcB=01, ALUOp=00. IRWrite=1 and PCWrite=1 only in the cycle where mem_ready=1 (Mealy-qualified strobe; the only non-Moore outputs).
  - DECODE: ALUSrcB=11, ALUOp=00.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegWrite=1, RegDst=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDIWB: RegWrite=1, RegDst=0.
- Latency with mem_ready tied to 1: lw 5 cycles; sw, R-type and addi 4; beq and j 3; illegal opcode 2.
- instr_count increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP.
  - Not incremented on the IDLE->FETCH transition or on an illegal-op return.
  - Wraps modulo 2^CNT_W.
- illegal_op stays set until reset.
- Reset asserted mid-instruction: immediate return to IDLE; all outputs drop to 0 asynchronously; no partial writes are issued after assertion.

Test Plan:
- Reset release, mem_ready=1: state sequence 0,1,2; all outputs 0 in IDLE; FETCH drives MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- Op=35, mem_ready=1 -> states 1,2,3,4,5,1; ALUOp=00 in MEMADR; MEMWB drives RegWrite=1, MemtoReg=1; instr_count 0->1.
- Op=0 then Op=4 -> EXEC drives ALUOp=10, ALUWB drives RegDst=1; BRANCH drives ALUOp=01, PCWriteCond=1, PCSource=01; instr_count=2.
- Op=43 with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 held 4 cycles, then FETCH; a FETCH stall likewise holds IRWrite=0 until mem_ready=1.
- Op=63 -> DECODE->FETCH, illegal_op=1 and sticky; instr_count unchanged; a following Op=2 executes JUMP (PCWrite=1, PCSource=10).
- rst_n pulsed low during MEMRD -> state=0 and all outputs 0 immediately; instr_count=0, illegal_op=0.
